ram_port_arbiter: RTL and testbench

Single-port arbiter and access sequencer for the processor's shared `RAM` word memory. Three requesters share the one RAM: instruction fetch (PC side), data load/store (register-file side) and the external program loader. The block accepts one request per cycle, registers it, drives the RAM address/enable/write lines for exactly one cycle, and returns a registered completion and read word. It sits between the processor top level and the `RAM` instance, and replaces direct muxing of the RAM read/write addresses.

---
 rtl/ram_arb_pkg.sv | 33 +++
 rtl/ram_port_arbiter_rr_pick.sv | 28 ++
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: requester indices,
// arbitration state and round-robin pointer helpers.
package ram_arb_pkg;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_LOAD  = 2;
    localparam int NUM_REQ   = 3;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [1:0]         req_idx_t;

    localparam req_vec_t MASK_LOAD_ONLY = 3'b100;
    localparam req_vec_t MASK_NO_LOAD   = 3'b011;
    localparam req_vec_t MASK_DATA_ONLY = 3'b010;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Modulo-3 increment; index 3 never occurs but wraps to 0 if it did.
    function automatic req_idx_t next_idx(input req_idx_t idx);
        return (idx >= req_idx_t'(NUM_REQ - 1)) ? req_idx_t'(0) : idx + req_idx_t'(1);
    endfunction

    function automatic req_idx_t onehot_to_idx(input req_vec_t v);
        if (v[REQ_LOAD]) return req_idx_t'(REQ_LOAD);
        if (v[REQ_DATA]) return req_idx_t'(REQ_DATA);
        return req_idx_t'(REQ_FETCH);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// the pointer, returned one-hot.
module rr_pick
    import ram_arb_pkg::*;
(
    input  req_vec_t elig_i,
    input  req_idx_t ptr_i,
    output req_vec_t win_o
);

    req_idx_t idx;
    logic     found;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no latch is inferred.
        win_o = '0;
        found = 1'b0;
        idx   = ptr_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: grants one of fetch/data/loader per cycle, drives
// the RAM for one cycle from a latched access, and returns done/rdata a cycle later.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           loader_mode,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
    input  logic                           lock,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [DATA_W-1:0]              rdata,
    output logic                           ram_write_EN,
    output logic                           ram_read_disEN,
    output logic [ADDR_W-1:0]              ram_read_address,
    output logic [ADDR_W-1:0]              ram_write_address,
    output logic [DATA_W-1:0]              ram_write_value,
    input  logic [DATA_W-1:0]              ram_word
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t         state_q, state_d;
    req_idx_t           ptr_q, ptr_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               prev_data_q, prev_data_d;
    req_idx_t           acc_owner_q, acc_owner_d;
    logic               acc_we_q, acc_we_d;
    logic [ADDR_W-1:0]  acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0]  acc_wdata_q, acc_wdata_d;
    req_vec_t           done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    req_vec_t elig_mask;
    req_vec_t elig;
    req_vec_t win;
    req_idx_t win_idx;
    logic     any_gnt;
    logic     lock_hold;
    logic     acc_read;
    logic     acc_write;

    // Eligibility: loader mode is exclusive; otherwise a live data lock
    // restricts the field to data until the counter saturates.
    always_comb begin
        lock_hold = lock && prev_data_q && (lock_cnt_q < CNT_W'(LOCK_MAX));
        if (loader_mode) begin
            elig_mask = MASK_LOAD_ONLY;
        end else if (lock_hold) begin
            elig_mask = MASK_DATA_ONLY;
        end else begin
            elig_mask = MASK_NO_LOAD;
        end
        elig = req_vec_t'(req) & elig_mask;
    end

    rr_pick u_rr_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .win_o  (win)
    );

    assign gnt     = win;
    assign any_gnt = |win;
    assign win_idx = onehot_to_idx(win);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a grant in any state opens an access next cycle.
    always_comb begin
        state_d = any_gnt ? ACCESS : IDLE;
    end

    // FSM outputs: the latched access drives the RAM only while in ACCESS.
    always_comb begin
        acc_read          = (state_q == ACCESS) && !acc_we_q;
        acc_write         = (state_q == ACCESS) &&  acc_we_q;
        ram_write_EN      = acc_write;
        ram_read_disEN    = !acc_read;
        ram_read_address  = acc_read  ? acc_addr_q  : '0;
        ram_write_address = acc_write ? acc_addr_q  : '0;
        ram_write_value   = acc_write ? acc_wdata_q : '0;
    end

    // Pointer, lock counter, access register and completion next-state.
    always_comb begin
        ptr_d       = any_gnt ? next_idx(win_idx) : ptr_q;
        prev_data_d = win[REQ_DATA];

        if (win[REQ_DATA] && lock) begin
            // A saturated run that still lands on data starts a fresh run.
            lock_cnt_d = (lock_cnt_q >= CNT_W'(LOCK_MAX)) ? CNT_W'(1)
                                                          : lock_cnt_q + CNT_W'(1);
        end else begin
            lock_cnt_d = '0;
        end

        acc_owner_d = acc_owner_q;
        acc_we_d    = acc_we_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        if (any_gnt) begin
            acc_owner_d = win_idx;
            acc_we_d    = we[win_idx];
            acc_addr_d  = addr[win_idx];
            acc_wdata_d = wdata[win_idx];
        end

        done_d = '0;
        if (state_q == ACCESS) begin
            done_d[acc_owner_q] = 1'b1;
        end
        rdata_d = acc_read ? ram_word : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= req_idx_t'(REQ_FETCH);
            lock_cnt_q  <= '0;
            prev_data_q <= 1'b0;
            acc_owner_q <= '0;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            prev_data_q <= prev_data_d;
            acc_owner_q <= acc_owner_d;
            acc_we_q    <= acc_we_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
        end
    end

    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed grant vectors push expected
// completions; a negedge monitor pops and compares them against done/rdata.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic                           clk;
    logic                           reset;
    logic                           loader_mode;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
    logic                           lock;
    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             done;
    logic [DATA_W-1:0]              rdata;
    logic                           ram_write_EN;
    logic                           ram_read_disEN;
    logic [ADDR_W-1:0]              ram_read_address;
    logic [ADDR_W-1:0]              ram_write_address;
    logic [DATA_W-1:0]              ram_write_value;
    logic [DATA_W-1:0]              ram_word;

    ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .loader_mode       (loader_mode),
        .req               (req),
        .we                (we),
        .addr              (addr),
        .wdata             (wdata),
        .lock              (lock),
        .gnt               (gnt),
        .done              (done),
        .rdata             (rdata),
        .ram_write_EN      (ram_write_EN),
        .ram_read_disEN    (ram_read_disEN),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write_value   (ram_write_value),
        .ram_word          (ram_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RAM model: bench pokes for preload, otherwise DUT writes.
    logic [DATA_W-1:0] mem [256];
    logic              poke_en;
    logic [7:0]        poke_addr;
    logic [DATA_W-1:0] poke_data;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (ram_write_EN) mem[ram_write_address[7:0]] <= ram_write_value;
    end
    assign ram_word = mem[ram_read_address[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic               is_rd;
        logic [DATA_W-1:0]  word;
        int                 cyc;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] exp_word [NUM_REQ];
    logic [DATA_W-1:0] last_rd;

    // Monitor: every done pulse must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (!reset) begin
            last_rd = '0;
        end else if (done !== '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done", 32'(done), 32'(e.done));
                check("done_latency", 32'(cyc - e.cyc), 32'd2);
                if (e.is_rd) begin
                    check("rdata", 32'(rdata), 32'(e.word));
                    last_rd = e.word;
                end else begin
                    check("rdata_hold", 32'(rdata), 32'(last_rd));
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [DATA_W-1:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // One arbitration cycle: drive inputs after the edge, check gnt mid-cycle,
    // and queue the expected completion for the granted requester.
    task automatic step(input logic [2:0] r, input logic [2:0] w, input logic lk,
                        input logic lm, input logic [2:0] exp_g, input bit track = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        req         = r;
        we          = w;
        lock        = lk;
        loader_mode = lm;
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(exp_g));
        if (track && exp_g != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_g[i]) begin
                    e.done  = exp_g;
                    e.is_rd = !w[i];
                    e.word  = exp_word[i];
                    e.cyc   = cyc;
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_rdata"}, 32'(rdata), 32'h0);
        check({tag, "_wen"}, 32'(ram_write_EN), 32'h0);
        check({tag, "_rdis"}, 32'(ram_read_disEN), 32'h1);
        check({tag, "_raddr"}, 32'(ram_read_address), 32'h0);
        check({tag, "_waddr"}, 32'(ram_write_address), 32'h0);
        check({tag, "_wval"}, 32'(ram_write_value), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        loader_mode = 1'b0;
        req         = '0;
        we          = '0;
        addr        = '0;
        wdata       = '0;
        lock        = 1'b0;
        poke_en     = 1'b0;
        poke_addr   = '0;
        poke_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) exp_word[i] = '0;

        poke(8'h05, 16'hA123);
        poke(8'h20, 16'h1111);
        poke(8'h21, 16'h2222);
        poke(8'h40, 16'h4444);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Fetch read of 0x0005.
        addr[REQ_FETCH]     = 16'h0005;
        exp_word[REQ_FETCH] = 16'hA123;
        step(3'b001, 3'b000, 1'b0, 1'b0, 3'b001);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        check("t1_raddr", 32'(ram_read_address), 32'h0005);
        check("t1_rdis", 32'(ram_read_disEN), 32'h0);
        check("t1_wen", 32'(ram_write_EN), 32'h0);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        check("idle_rdis", 32'(ram_read_disEN), 32'h1);

        // Contention: pointer sits at data after the fetch grant.
        addr[REQ_FETCH]     = 16'h0020;
        addr[REQ_DATA]      = 16'h0021;
        exp_word[REQ_FETCH] = 16'h1111;
        exp_word[REQ_DATA]  = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            step(3'b011, 3'b000, 1'b0, 1'b0, (i % 2 == 0) ? 3'b010 : 3'b001);
        end
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);

        // Data writes 0x00FF to 0x0010, fetch reads it back next cycle.
        addr[REQ_DATA]      = 16'h0010;
        wdata[REQ_DATA]     = 16'h00FF;
        addr[REQ_FETCH]     = 16'h0010;
        exp_word[REQ_FETCH] = 16'h00FF;
        step(3'b010, 3'b010, 1'b0, 1'b0, 3'b010);
        step(3'b001, 3'b000, 1'b0, 1'b0, 3'b001);
        check("t3_wen", 32'(ram_write_EN), 32'h1);
        check("t3_waddr", 32'(ram_write_address), 32'h0010);
        check("t3_wval", 32'(ram_write_value), 32'h00FF);
        check("t3_rdis_w", 32'(ram_read_disEN), 32'h1);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        check("t3_wen_off", 32'(ram_write_EN), 32'h0);
        check("t3_rdis_r", 32'(ram_read_disEN), 32'h0);
        check("t3_raddr", 32'(ram_read_address), 32'h0010);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);

        // Lock: four data grants, forced fetch, then data again.
        addr[REQ_FETCH]     = 16'h0020;
        addr[REQ_DATA]      = 16'h0021;
        exp_word[REQ_FETCH] = 16'h1111;
        exp_word[REQ_DATA]  = 16'h2222;
        for (int i = 0; i < 7; i++) begin
            step(3'b011, 3'b000, 1'b1, 1'b0, (i == 4) ? 3'b001 : 3'b010);
        end
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);

        // Loader mode: loader exclusive, then excluded once cleared.
        addr[REQ_LOAD]     = 16'h0040;
        exp_word[REQ_LOAD] = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 3'b000, 1'b0, 1'b1, 3'b100);
        end
        step(3'b001, 3'b000, 1'b0, 1'b1, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 3'b000, 1'b0, 1'b0, (i % 2 == 0) ? 3'b001 : 3'b010);
        end
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);
        check("pre_reset_drain", 32'(sb_q.size()), 32'h0);

        // Reset asserted in the middle of a write access.
        addr[REQ_DATA]  = 16'h0030;
        wdata[REQ_DATA] = 16'hBEEF;
        step(3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0);
        @(posedge clk);
        #1;
        req = '0;
        we  = '0;
        #2;
        check("t6_wen_live", 32'(ram_write_EN), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        check("midreset_done", 32'(done), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Pointer back at fetch after reset.
        addr[REQ_FETCH]     = 16'h0005;
        exp_word[REQ_FETCH] = 16'hA123;
        step(3'b011, 3'b000, 1'b0, 1'b0, 3'b001);
        step(3'b000, 3'b000, 1'b0, 1'b0, 3'b000);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("final_drain", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
